// File: rtl/contrast_stretch.sv
// Per-frame auto-contrast stage for one 8-bit channel.
// Statistics (min/max) gathered over frame N set the stretch applied to frame N+1.
// The gain 65280/(max-min) comes from a 16-cycle restoring divider that runs
// in vertical blanking. Data and syncs have a fixed 3-cycle latency.
module contrast_stretch #(
    parameter logic        VS_POL    = 1'b1,
    parameter int unsigned MIN_RANGE = 16
) (
    input  logic       I_CLK,
    input  logic       I_Rst_n,
    input  logic [7:0] Pre_Data,
    input  logic       I_De,
    input  logic       I_V_Sync,
    input  logic       I_H_Sync,
    input  logic       I_Bypass,
    output logic [7:0] Post_Data,
    output logic       O_De,
    output logic       O_V_Sync,
    output logic       O_H_Sync
);

    localparam logic [8:0]  MIN_RANGE_C = 9'(MIN_RANGE);
    localparam logic [12:0] GAIN_ONE    = 13'd256;
    localparam logic [15:0] DIVIDEND    = 16'd65280;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_DIV    = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Frame-start detection
    logic        vs_prev_r;
    logic        frame_start_s;

    // Statistics accumulators and latched frame statistics
    logic [7:0]  cur_min_r;
    logic [7:0]  cur_max_r;
    logic        cur_seen_r;
    logic [7:0]  st_min_r;
    logic [7:0]  st_max_r;
    logic        st_seen_r;
    logic [7:0]  range_s;

    // Coefficient control
    state_t      state_r;
    logic [16:0] rem_r;
    logic [15:0] quo_r;
    logic [7:0]  divisor_r;
    logic [3:0]  cnt_r;
    logic [16:0] shifted_s;
    logic [16:0] trial_s;
    logic [16:0] rem_next_s;
    logic [15:0] quo_next_s;
    logic [7:0]  min_pend_r;
    logic [12:0] gain_pend_r;
    logic        bypass_pend_r;
    logic [7:0]  min_a_r;
    logic [12:0] gain_a_r;
    logic        bypass_a_r;

    // Datapath pipeline
    logic [7:0]  diff_r;
    logic [20:0] prod_r;
    logic [7:0]  data_d1_r;
    logic [7:0]  data_d2_r;
    logic        byp_d1_r;
    logic        byp_d2_r;
    logic [7:0]  clamp_s;
    logic [2:0]  sync_d1_r;
    logic [2:0]  sync_d2_r;

    // Frame-start pulse on the selected edge of I_V_Sync
    always_comb begin
        if (VS_POL) begin
            frame_start_s = I_V_Sync & ~vs_prev_r;
        end else begin
            frame_start_s = ~I_V_Sync & vs_prev_r;
        end
    end

    // Previous vertical sync value for edge detection
    always_ff @(posedge I_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            vs_prev_r <= 1'b0;
        end else begin
            vs_prev_r <= I_V_Sync;
        end
    end

    // Min/max accumulation over active pixels, latched and cleared at frame start
    always_ff @(posedge I_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            cur_min_r  <= 8'hFF;
            cur_max_r  <= 8'h00;
            cur_seen_r <= 1'b0;
            st_min_r   <= 8'hFF;
            st_max_r   <= 8'h00;
            st_seen_r  <= 1'b0;
        end else if (frame_start_s) begin
            st_min_r   <= cur_min_r;
            st_max_r   <= cur_max_r;
            st_seen_r  <= cur_seen_r;
            cur_min_r  <= 8'hFF;
            cur_max_r  <= 8'h00;
            cur_seen_r <= 1'b0;
        end else if (I_De) begin
            cur_seen_r <= 1'b1;
            if (Pre_Data < cur_min_r) begin
                cur_min_r <= Pre_Data;
            end
            if (Pre_Data > cur_max_r) begin
                cur_max_r <= Pre_Data;
            end
        end
    end

    // Range of the latched statistics; only used when st_seen_r guarantees max >= min
    always_comb begin
        range_s = st_max_r - st_min_r;
    end

    // One restoring-division step: shift in next dividend bit, subtract if it fits
    always_comb begin
        shifted_s = {rem_r[15:0], quo_r[15]};
        trial_s   = shifted_s - {9'd0, divisor_r};
        if (!trial_s[16]) begin
            rem_next_s = trial_s;
            quo_next_s = {quo_r[14:0], 1'b1};
        end else begin
            rem_next_s = shifted_s;
            quo_next_s = {quo_r[14:0], 1'b0};
        end
    end

    // Coefficient FSM: check stats, divide, then commit in a gap between active pixels
    always_ff @(posedge I_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            state_r       <= ST_IDLE;
            rem_r         <= 17'd0;
            quo_r         <= 16'd0;
            divisor_r     <= 8'd0;
            cnt_r         <= 4'd0;
            min_pend_r    <= 8'd0;
            gain_pend_r   <= GAIN_ONE;
            bypass_pend_r <= 1'b0;
            min_a_r       <= 8'd0;
            gain_a_r      <= GAIN_ONE;
            bypass_a_r    <= 1'b0;
        end else if (frame_start_s) begin
            // A new frame start always restarts the sequence; active set untouched
            bypass_pend_r <= I_Bypass;
            state_r       <= ST_CHECK;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                ST_CHECK: begin
                    if (!st_seen_r) begin
                        min_pend_r  <= min_a_r;
                        gain_pend_r <= gain_a_r;
                        state_r     <= ST_COMMIT;
                    end else if ({1'b0, range_s} < MIN_RANGE_C) begin
                        min_pend_r  <= 8'd0;
                        gain_pend_r <= GAIN_ONE;
                        state_r     <= ST_COMMIT;
                    end else begin
                        rem_r     <= 17'd0;
                        quo_r     <= DIVIDEND;
                        divisor_r <= range_s;
                        cnt_r     <= 4'd0;
                        state_r   <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    cnt_r <= cnt_r + 4'd1;
                    if (cnt_r == 4'd15) begin
                        // Range >= 16 bounds the quotient to 4080, so 13 bits suffice
                        gain_pend_r <= quo_next_s[12:0];
                        min_pend_r  <= st_min_r;
                        state_r     <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (!I_De) begin
                        min_a_r    <= min_pend_r;
                        gain_a_r   <= gain_pend_r;
                        bypass_a_r <= bypass_pend_r;
                        state_r    <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Saturate the scaled product to 8 bits
    always_comb begin
        if (|prod_r[20:16]) begin
            clamp_s = 8'hFF;
        end else begin
            clamp_s = prod_r[15:8];
        end
    end

    // Three-stage stretch datapath: subtract/saturate, multiply, shift/clamp
    always_ff @(posedge I_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            diff_r    <= 8'd0;
            prod_r    <= 21'd0;
            data_d1_r <= 8'd0;
            data_d2_r <= 8'd0;
            byp_d1_r  <= 1'b0;
            byp_d2_r  <= 1'b0;
            Post_Data <= 8'd0;
        end else begin
            if (Pre_Data > min_a_r) begin
                diff_r <= Pre_Data - min_a_r;
            end else begin
                diff_r <= 8'd0;
            end
            data_d1_r <= Pre_Data;
            byp_d1_r  <= bypass_a_r;
            prod_r    <= {13'd0, diff_r} * {8'd0, gain_a_r};
            data_d2_r <= data_d1_r;
            byp_d2_r  <= byp_d1_r;
            if (byp_d2_r) begin
                Post_Data <= data_d2_r;
            end else begin
                Post_Data <= clamp_s;
            end
        end
    end

    // Matching 3-stage delay line for De and syncs
    always_ff @(posedge I_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            sync_d1_r <= 3'd0;
            sync_d2_r <= 3'd0;
            O_De      <= 1'b0;
            O_V_Sync  <= 1'b0;
            O_H_Sync  <= 1'b0;
        end else begin
            sync_d1_r <= {I_De, I_V_Sync, I_H_Sync};
            sync_d2_r <= sync_d1_r;
            O_De      <= sync_d2_r[2];
            O_V_Sync  <= sync_d2_r[1];
            O_H_Sync  <= sync_d2_r[0];
        end
    end

endmodule

// File: tb/tb_contrast_stretch.sv
// Directed scoreboard bench for contrast_stretch.
// Stimulus pushes hand-computed pixel results into a queue; a negedge monitor
// pops them whenever O_De is high and also checks the 3-cycle sync delay.
module tb_contrast_stretch;

    logic       I_CLK = 1'b0;
    logic       I_Rst_n = 1'b0;
    logic [7:0] Pre_Data = 8'd0;
    logic       I_De = 1'b0;
    logic       I_V_Sync = 1'b0;
    logic       I_H_Sync = 1'b0;
    logic       I_Bypass = 1'b0;
    logic [7:0] Post_Data;
    logic       O_De;
    logic       O_V_Sync;
    logic       O_H_Sync;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [2:0] h0 = 3'd0;
    logic [2:0] h1 = 3'd0;
    logic [2:0] h2 = 3'd0;
    logic end_chk = 1'b0;
    logic end_done = 1'b0;

    contrast_stretch #(.VS_POL(1'b1), .MIN_RANGE(16)) dut (
        .I_CLK     (I_CLK),
        .I_Rst_n   (I_Rst_n),
        .Pre_Data  (Pre_Data),
        .I_De      (I_De),
        .I_V_Sync  (I_V_Sync),
        .I_H_Sync  (I_H_Sync),
        .I_Bypass  (I_Bypass),
        .Post_Data (Post_Data),
        .O_De      (O_De),
        .O_V_Sync  (O_V_Sync),
        .O_H_Sync  (O_H_Sync)
    );

    always #5 I_CLK = ~I_CLK;

    // Reference 3-deep history of {De, VS, HS} as sampled by the DUT
    always @(posedge I_CLK or negedge I_Rst_n) begin
        if (!I_Rst_n) begin
            h0 <= 3'd0;
            h1 <= 3'd0;
            h2 <= 3'd0;
        end else begin
            h0 <= {I_De, I_V_Sync, I_H_Sync};
            h1 <= h0;
            h2 <= h1;
        end
    end

    // Monitor: reset state, sync delay and scoreboard pixel compare
    always @(negedge I_CLK) begin
        if (!I_Rst_n) begin
            checks++;
            if ({Post_Data, O_De, O_V_Sync, O_H_Sync} != 11'd0) begin
                errors++;
                $display("FAIL reset_outputs: got data=%h de=%b vs=%b hs=%b, want all 0",
                         Post_Data, O_De, O_V_Sync, O_H_Sync);
            end
        end else begin
            checks++;
            if ({O_De, O_V_Sync, O_H_Sync} != h2) begin
                errors++;
                $display("FAIL sync_delay at %0t: got %b, want %b",
                         $time, {O_De, O_V_Sync, O_H_Sync}, h2);
            end
            if (O_De) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pixel at %0t: got %h, want none", $time, Post_Data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (Post_Data !== e) begin
                        errors++;
                        $display("FAIL pixel at %0t: got %h, want %h", $time, Post_Data, e);
                    end
                end
            end
        end
        if (end_chk && !end_done) begin
            end_done <= 1'b1;
            checks++;
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL drain: %0d pixels missing, want 0", exp_q.size());
            end
        end
    end

    // One clock of stimulus; expected output queued for active pixels
    task automatic cyc(input logic [7:0] d, input logic de, input logic vs,
                       input logic hs, input logic [7:0] e);
        Pre_Data = d;
        I_De     = de;
        I_V_Sync = vs;
        I_H_Sync = hs;
        if (de) begin
            exp_q.push_back(e);
        end
        @(posedge I_CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(8'd0, 1'b0, 1'b0, 1'b0, 8'd0);
        end
    endtask

    task automatic px(input logic [7:0] d, input logic [7:0] e);
        cyc(d, 1'b1, 1'b0, 1'b0, e);
    endtask

    // Vertical sync pulse plus blanking long enough for divide and commit
    task automatic vblank(input logic byp);
        I_Bypass = byp;
        for (int i = 0; i < 3; i++) begin
            cyc(8'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        end
        idle(22);
        cyc(8'd0, 1'b0, 1'b0, 1'b1, 8'd0);
    endtask

    initial begin
        repeat (3) @(posedge I_CLK);
        #1;
        I_Rst_n = 1'b1;
        idle(3);

        // F1: first frame is identity
        vblank(1'b0);
        px(8'h40, 8'h40); px(8'h80, 8'h80); px(8'hC0, 8'hC0);
        idle(4);
        // F2: min 0x40 gain 510; plus negative saturation and clamp
        vblank(1'b0);
        px(8'h40, 8'h00); px(8'h80, 8'h7F); px(8'hC0, 8'hFF);
        px(8'h30, 8'h00); px(8'hD0, 8'hFF);
        idle(4);
        // F3: min 0x30 gain 408 (range 160); stats 0x70..0x78
        vblank(1'b0);
        px(8'h70, 8'h66); px(8'h78, 8'h72);
        idle(4);
        // F4: range 8 below threshold -> identity
        vblank(1'b0);
        px(8'h55, 8'h55); px(8'h40, 8'h40); px(8'hC0, 8'hC0);
        idle(4);
        // F5: gain 510 again
        vblank(1'b0);
        px(8'h40, 8'h00); px(8'h80, 8'h7F); px(8'hC0, 8'hFF);
        idle(4);
        // F6: no active pixels
        vblank(1'b0);
        idle(6);
        // F7: empty stats keep min 0x40 gain 510
        vblank(1'b0);
        px(8'h80, 8'h7F); px(8'h40, 8'h00); px(8'hC0, 8'hFF);
        idle(4);
        // F8: bypass sampled at frame start
        vblank(1'b1);
        px(8'h80, 8'h80); px(8'h40, 8'h40); px(8'hC0, 8'hC0);
        idle(4);
        // F9: bypass released, stretch resumes
        vblank(1'b0);
        px(8'h80, 8'h7F); px(8'h40, 8'h00); px(8'hC0, 8'hFF);
        idle(4);

        // Reset during the divider
        I_Bypass = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(8'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        end
        idle(2);
        I_Rst_n = 1'b0;
        idle(4);
        I_Rst_n = 1'b1;
        idle(20);
        // F11: identity after reset, stats 0x30..0x80
        vblank(1'b0);
        px(8'h80, 8'h80); px(8'h30, 8'h30);
        idle(4);

        // Abort: second edge 4 cycles after the first, commit 18 cycles later
        cyc(8'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        cyc(8'h20, 1'b1, 1'b0, 1'b0, 8'h20);
        cyc(8'h60, 1'b1, 1'b0, 1'b0, 8'h60);
        idle(1);
        cyc(8'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        cyc(8'd0, 1'b0, 1'b1, 1'b0, 8'd0);
        idle(15);
        px(8'h50, 8'h50);
        idle(1);
        px(8'h30, 8'h3F);
        px(8'h60, 8'hFF);
        px(8'h20, 8'h00);
        idle(8);

        end_chk = 1'b1;
        @(negedge I_CLK);
        @(negedge I_CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
